// File: rtl/id_ex_if.sv
// Decode->Execute boundary bundle: D-side inputs, registered E-side outputs and hazard controls.
// PERF_CNT_EN adds the BubbleCnt/LoadUseCnt counter outputs.
interface id_ex_if #(
    parameter int XLEN = 32
`ifdef PERF_CNT_EN
    ,
    parameter int PERF_W = 32
`endif
);
    logic            RegWriteD, MemWriteD, ALUSrcD, BranchD, JumpD;
    logic [1:0]      ResultSrcD;
    logic [2:0]      ALUControlD;
    logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
    logic [4:0]      Rs1D, Rs2D, RdD;
    logic            PCSrcE;

    logic            RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE;
    logic [1:0]      ResultSrcE;
    logic [2:0]      ALUControlE;
    logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]      Rs1E, Rs2E, RdE;
    logic            ValidE, StallF, StallD, FlushD, FlushE;
`ifdef PERF_CNT_EN
    logic [PERF_W-1:0] BubbleCnt, LoadUseCnt;
`endif

    modport master (
        output RegWriteD, MemWriteD, ResultSrcD, ALUControlD, ALUSrcD, BranchD, JumpD,
               RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD, PCSrcE,
        input  RegWriteE, MemWriteE, ResultSrcE, ALUControlE, ALUSrcE, BranchE, JumpE,
               RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE,
               ValidE, StallF, StallD, FlushD, FlushE
`ifdef PERF_CNT_EN
        , input BubbleCnt, LoadUseCnt
`endif
    );

    modport slave (
        input  RegWriteD, MemWriteD, ResultSrcD, ALUControlD, ALUSrcD, BranchD, JumpD,
               RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD, PCSrcE,
        output RegWriteE, MemWriteE, ResultSrcE, ALUControlE, ALUSrcE, BranchE, JumpE,
               RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE,
               ValidE, StallF, StallD, FlushD, FlushE
`ifdef PERF_CNT_EN
        , output BubbleCnt, LoadUseCnt
`endif
    );
endinterface

// File: rtl/id_ex_stage.sv
// Decode->Execute pipeline register with local load-use detection and F/D/E stall/flush control.
// Defining PERF_CNT_EN adds saturating BubbleCnt and LoadUseCnt counters.
module id_ex_stage #(
    parameter int XLEN = 32
`ifdef PERF_CNT_EN
    ,
    parameter int PERF_W = 32
`endif
) (
    input logic    clk,
    input logic    rst,
    id_ex_if.slave bus
);
    typedef struct packed {
        logic            reg_write;
        logic            mem_write;
        logic [1:0]      result_src;
        logic [2:0]      alu_control;
        logic            alu_src;
        logic            branch;
        logic            jump;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm_ext;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            valid;
    } e_stage_t;

    e_stage_t d_s;
    e_stage_t e_r;
    logic     lw_stall_s;
    logic     stall_s;
    logic     flush_e_s;

    // Hazard detection: a valid load in E writing a nonzero rd read by D forces one bubble
    always_comb begin
        lw_stall_s = (e_r.result_src == 2'b01) && e_r.valid && (e_r.rd != 5'd0) &&
                     ((e_r.rd == bus.Rs1D) || (e_r.rd == bus.Rs2D));
        stall_s    = lw_stall_s && !bus.PCSrcE;
        flush_e_s  = lw_stall_s || bus.PCSrcE;
    end

    // Gather the decode-stage fields into the next E record
    always_comb begin
        d_s.reg_write   = bus.RegWriteD;
        d_s.mem_write   = bus.MemWriteD;
        d_s.result_src  = bus.ResultSrcD;
        d_s.alu_control = bus.ALUControlD;
        d_s.alu_src     = bus.ALUSrcD;
        d_s.branch      = bus.BranchD;
        d_s.jump        = bus.JumpD;
        d_s.rd1         = bus.RD1D;
        d_s.rd2         = bus.RD2D;
        d_s.imm_ext     = bus.ImmExtD;
        d_s.pc          = bus.PCD;
        d_s.pc_plus4    = bus.PCPlus4D;
        d_s.rs1         = bus.Rs1D;
        d_s.rs2         = bus.Rs2D;
        d_s.rd          = bus.RdD;
        d_s.valid       = 1'b1;
    end

    // E register: a flush loads an all-zero bubble so its RdE can never match a source
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_r <= '0;
        end else if (flush_e_s) begin
            e_r <= '0;
        end else begin
            e_r <= d_s;
        end
    end

    assign bus.RegWriteE   = e_r.reg_write;
    assign bus.MemWriteE   = e_r.mem_write;
    assign bus.ResultSrcE  = e_r.result_src;
    assign bus.ALUControlE = e_r.alu_control;
    assign bus.ALUSrcE     = e_r.alu_src;
    assign bus.BranchE     = e_r.branch;
    assign bus.JumpE       = e_r.jump;
    assign bus.RD1E        = e_r.rd1;
    assign bus.RD2E        = e_r.rd2;
    assign bus.ImmExtE     = e_r.imm_ext;
    assign bus.PCE         = e_r.pc;
    assign bus.PCPlus4E    = e_r.pc_plus4;
    assign bus.Rs1E        = e_r.rs1;
    assign bus.Rs2E        = e_r.rs2;
    assign bus.RdE         = e_r.rd;
    assign bus.ValidE      = e_r.valid;
    assign bus.StallF      = stall_s;
    assign bus.StallD      = stall_s;
    assign bus.FlushD      = bus.PCSrcE;
    assign bus.FlushE      = flush_e_s;

`ifdef PERF_CNT_EN
    logic [PERF_W-1:0] bubble_cnt_r;
    logic [PERF_W-1:0] load_use_cnt_r;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        if (v == {PERF_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(PERF_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Saturating event counters: bubbles inserted and load-use stalls taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_r   <= '0;
            load_use_cnt_r <= '0;
        end else begin
            if (flush_e_s) begin
                bubble_cnt_r <= sat_inc(bubble_cnt_r);
            end
            if (stall_s) begin
                load_use_cnt_r <= sat_inc(load_use_cnt_r);
            end
        end
    end

    assign bus.BubbleCnt  = bubble_cnt_r;
    assign bus.LoadUseCnt = load_use_cnt_r;
`endif
endmodule
